// File: rtl/pci_mem_target.sv
// pci_mem_target
//   PCI memory target front-end. Posted writes are queued in a small FIFO
//   and drained to a simple valid/ready memory request port. Reads first
//   wait for the write FIFO to drain, so a read never overtakes an earlier
//   posted write. They then issue one memory request and return a single
//   word as a disconnect-with-data.
//
//   Optional feature (macro PCI_MEM_TARGET_RETRY_EN):
//     When defined, a read that waits RETRY_CYCLES cycles is disconnected
//     with a retry (s_term=1, s_ready=0). The read stays pending. A later
//     read hit to the same address completes it. A hit to any other address
//     while the read is pending gets a one-cycle target abort.
//     When not defined there is no timeout, and reads wait indefinitely.
//
//   Ports
//     clk, rst                core clock, asynchronous active-low reset
//     s_hit/addr/s_wrdn       address phase: BAR hit, address, 1=write
//     s_data/s_data_vld       burst in progress / data phase completes
//     adio_out/s_cbe_n        write data, active-low byte enables
//     adio_in                 registered read data
//     s_ready/s_term/s_abort  target ready / disconnect / target abort
//     mem_req_*               memory request (valid/ready handshake)
//     mem_rsp_valid/_data     read data return
//     wfifo_level             posted-write FIFO occupancy
module pci_mem_target #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 24,
    parameter int WFIFO_DEPTH  = 8,
    parameter int RETRY_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_hit,
    input  logic [31:0]                    addr,
    input  logic                           s_wrdn,
    input  logic                           s_data,
    input  logic                           s_data_vld,
    input  logic [DATA_W-1:0]              adio_out,
    input  logic [DATA_W/8-1:0]            s_cbe_n,
    output logic [DATA_W-1:0]              adio_in,
    output logic                           s_ready,
    output logic                           s_term,
    output logic                           s_abort,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_we,
    output logic [ADDR_W-1:0]              mem_req_addr,
    output logic [DATA_W-1:0]              mem_req_wdata,
    output logic [DATA_W/8-1:0]            mem_req_be,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_W-1:0]              mem_rsp_data,
    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = $clog2(BE_W);
    localparam int IDX_W  = $clog2(WFIFO_DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BE_W);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_WAIT  = 3'd4,
`ifdef PCI_MEM_TARGET_RETRY_EN
        ST_RETRY    = 3'd6,
`endif
        ST_RD_DATA  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_W-1:0]   adio_q, adio_d;

    // FIFO storage (no reset needed: validity is tracked by the pointers)
    logic [ADDR_W-1:0]   fa_q [WFIFO_DEPTH];
    logic [DATA_W-1:0]   fd_q [WFIFO_DEPTH];
    logic [BE_W-1:0]     fb_q [WFIFO_DEPTH];

    logic [ADDR_W-1:0]   hit_addr_s;
    logic [PTR_W-1:0]    level_s;
    logic                full_s, empty_s, last_s, push_s, pop_s, idle_hit_s, new_txn_s;

    generate
        if (ADDR_W < 32) begin : g_addr_unused
            logic unused_addr_s;
            assign unused_addr_s = ^addr[31:ADDR_W];
        end
    endgenerate

    assign hit_addr_s = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign level_s    = wptr_q - rptr_q;
    assign full_s     = (level_s == PTR_W'(WFIFO_DEPTH));
    assign empty_s    = (wptr_q == rptr_q);
    // Current word is the top of the address space: the next one would wrap.
    assign last_s     = &addr_q[ADDR_W-1:OFF_W];
    assign push_s     = (state_q == ST_WR) && s_data_vld && !full_s;
    // RD_REQ is only reached with the FIFO empty, so the head never competes with a read.
    assign pop_s      = !empty_s && mem_req_ready;
    assign idle_hit_s = (state_q == ST_IDLE) && s_hit;

`ifdef PCI_MEM_TARGET_RETRY_EN
    localparam int CNT_W = $clog2(RETRY_CYCLES + 1) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d, sent_q, sent_d, got_q, got_d, abort_q, abort_d;
    logic             timeout_s, match_s, retry_hit_s, cap_pend_s, got_now_s;

    assign timeout_s   = (cnt_q >= CNT_W'(RETRY_CYCLES - 1));
    assign match_s     = !s_wrdn && (hit_addr_s == addr_q);
    assign retry_hit_s = idle_hit_s && pend_q && match_s;
    // A response owed to a retried read may land after the retry disconnect.
    assign cap_pend_s  = mem_rsp_valid && sent_q &&
                         ((state_q == ST_RETRY) || (state_q == ST_IDLE));
    assign got_now_s   = got_q || cap_pend_s;
    assign new_txn_s   = idle_hit_s && !pend_q;
`else
    assign new_txn_s   = idle_hit_s;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_hit) begin
                    state_d = s_wrdn ? ST_WR : ST_RD_DRAIN;
`ifdef PCI_MEM_TARGET_RETRY_EN
                    if (pend_q) begin
                        if (match_s) begin
                            state_d = got_now_s ? ST_RD_DATA :
                                      (sent_q ? ST_RD_WAIT : ST_RD_DRAIN);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = s_wrdn ? ST_WR : ST_RD_DRAIN;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (push_s && last_s) begin
                    state_d = ST_IDLE;
                end else if (!s_data) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_RD_DRAIN: begin
`ifdef PCI_MEM_TARGET_RETRY_EN
                if (timeout_s) begin
                    state_d = ST_RETRY;
                end else
`endif
                if (empty_s) begin
                    state_d = ST_RD_REQ;
                end else begin
                    state_d = ST_RD_DRAIN;
                end
            end
            ST_RD_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_RD_WAIT;
                end else
`ifdef PCI_MEM_TARGET_RETRY_EN
                if (timeout_s) begin
                    state_d = ST_RETRY;
                end else
`endif
                begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = ST_RD_DATA;
                end else
`ifdef PCI_MEM_TARGET_RETRY_EN
                if (timeout_s) begin
                    state_d = ST_RETRY;
                end else
`endif
                begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_DATA: state_d = ST_IDLE;
`ifdef PCI_MEM_TARGET_RETRY_EN
            ST_RETRY:   state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        s_ready       = 1'b0;
        s_term        = 1'b0;
        mem_req_valid = !empty_s;
        mem_req_we    = 1'b1;
        mem_req_addr  = fa_q[rptr_q[IDX_W-1:0]];
        mem_req_wdata = fd_q[rptr_q[IDX_W-1:0]];
        mem_req_be    = fb_q[rptr_q[IDX_W-1:0]];
        case (state_q)
            ST_WR: begin
                s_ready = !full_s;
                s_term  = last_s;
            end
            ST_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b0;
                mem_req_addr  = addr_q;
                mem_req_wdata = {DATA_W{1'b0}};
                mem_req_be    = {BE_W{1'b1}};
            end
            ST_RD_DATA: begin
                s_ready = 1'b1;
                s_term  = 1'b1;
            end
`ifdef PCI_MEM_TARGET_RETRY_EN
            ST_RETRY: begin
                s_term = 1'b1;
            end
`endif
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

`ifdef PCI_MEM_TARGET_RETRY_EN
    assign s_abort = abort_q;
`else
    assign s_abort = 1'b0;
`endif
    assign adio_in     = adio_q;
    assign wfifo_level = level_s;

    // Datapath next-state: address, FIFO pointers, read data
    always_comb begin
        if (new_txn_s) begin
            addr_d = hit_addr_s;
        end else if (push_s) begin
            addr_d = addr_q + ADDR_STEP;
        end else begin
            addr_d = addr_q;
        end
        wptr_d = push_s ? (wptr_q + PTR_W'(1)) : wptr_q;
        rptr_d = pop_s  ? (rptr_q + PTR_W'(1)) : rptr_q;
        if ((state_q == ST_RD_WAIT) && mem_rsp_valid) begin
            adio_d = mem_rsp_data;
        end else
`ifdef PCI_MEM_TARGET_RETRY_EN
        if (cap_pend_s) begin
            adio_d = mem_rsp_data;
        end else
`endif
        begin
            adio_d = adio_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= {ADDR_W{1'b0}};
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
            adio_q <= {DATA_W{1'b0}};
        end else begin
            addr_q <= addr_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            adio_q <= adio_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_s) begin
            fa_q[wptr_q[IDX_W-1:0]] <= addr_q;
            fd_q[wptr_q[IDX_W-1:0]] <= adio_out;
            fb_q[wptr_q[IDX_W-1:0]] <= ~s_cbe_n;
        end
    end

`ifdef PCI_MEM_TARGET_RETRY_EN
    // Retry bookkeeping next-state
    always_comb begin
        if (new_txn_s || retry_hit_s) begin
            cnt_d = CNT_W'(1);
        end else if ((state_q == ST_RD_DRAIN) || (state_q == ST_RD_REQ) ||
                     (state_q == ST_RD_WAIT)) begin
            cnt_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        if (state_q == ST_RETRY) begin
            pend_d = 1'b1;
        end else if (retry_hit_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        // sent: a read request was accepted and its response is still owed
        if ((state_q == ST_RD_REQ) && mem_req_ready) begin
            sent_d = 1'b1;
        end else if (((state_q == ST_RD_WAIT) && mem_rsp_valid) || cap_pend_s) begin
            sent_d = 1'b0;
        end else begin
            sent_d = sent_q;
        end
        if (retry_hit_s) begin
            got_d = 1'b0;
        end else if (cap_pend_s) begin
            got_d = 1'b1;
        end else begin
            got_d = got_q;
        end
        abort_d = idle_hit_s && pend_q && !match_s;
    end

    // Retry bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= {CNT_W{1'b0}};
            pend_q  <= 1'b0;
            sent_q  <= 1'b0;
            got_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sent_q  <= sent_d;
            got_q   <= got_d;
            abort_q <= abort_d;
        end
    end
`endif

endmodule

// File: tb/tb_pci_mem_target.sv
module tb_pci_mem_target;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_hit, s_wrdn, s_data, s_data_vld;
    logic [31:0]        addr;
    logic [DATA_W-1:0]  adio_out, adio_in;
    logic [3:0]         s_cbe_n;
    logic               s_ready, s_term, s_abort;
    logic               mem_req_valid, mem_req_ready, mem_req_we;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic [DATA_W-1:0]  mem_req_wdata;
    logic [3:0]         mem_req_be;
    logic               mem_rsp_valid;
    logic [DATA_W-1:0]  mem_rsp_data;
    logic [3:0]         wfifo_level;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0]  mq_addr[$];
    logic [31:0]        mq_data[$];
    logic [3:0]         mq_be[$];
    logic               mq_we[$];

    pci_mem_target #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WFIFO_DEPTH(8), .RETRY_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .s_hit(s_hit), .addr(addr), .s_wrdn(s_wrdn),
        .s_data(s_data), .s_data_vld(s_data_vld), .adio_out(adio_out), .s_cbe_n(s_cbe_n),
        .adio_in(adio_in), .s_ready(s_ready), .s_term(s_term), .s_abort(s_abort),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .wfifo_level(wfifo_level)
    );

    always #5 clk = ~clk;

    // Record every accepted memory request.
    always @(posedge clk) begin
        if (rst && mem_req_valid && mem_req_ready) begin
            mq_addr.push_back(mem_req_addr);
            mq_data.push_back(mem_req_wdata);
            mq_be.push_back(mem_req_be);
            mq_we.push_back(mem_req_we);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mq();
        mq_addr.delete();
        mq_data.delete();
        mq_be.delete();
        mq_we.delete();
    endtask

    // Drive one data phase and wait (bounded) until the target accepts it.
    task automatic phase(input logic [31:0] d, output bit ok);
        s_data_vld = 1'b1;
        adio_out   = d;
        s_cbe_n    = 4'h0;
        ok         = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_data_vld = 1'b0;
    endtask

    task automatic wait_mq(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (mq_we.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic hit(input logic [31:0] a, input logic wr);
        s_hit = 1'b1; addr = a; s_wrdn = wr;
        tick(1);
        s_hit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        checks++; if (s_term !== 1'b0) begin errors++; $display("FAIL reset_s_term: got %b want 0", s_term); end
        checks++; if (s_abort !== 1'b0) begin errors++; $display("FAIL reset_s_abort: got %b want 0", s_abort); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (adio_in !== 32'h0) begin errors++; $display("FAIL reset_adio_in: got %h want 0", adio_in); end
        checks++; if (wfifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", wfifo_level); end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_write_burst();
        bit ok;
        logic [31:0] exp_d;
        clear_mq();
        mem_req_ready = 1'b1;
        hit(32'h0000_0100, 1'b1);
        s_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h11 * (i + 1);
            phase(exp_d, ok);
            checks++; if (!ok) begin errors++; $display("FAIL wb_phase%0d: got no accept want accept", i); end
        end
        s_data = 1'b0;
        tick(4);
        checks++; if (mq_we.size() != 4) begin errors++; $display("FAIL wb_count: got %0d want 4", mq_we.size()); end
        for (int i = 0; i < 4; i++) begin
            if (mq_we.size() > i) begin
                exp_d = 32'h11 * (i + 1);
                checks++; if (mq_addr[i] !== 24'h100 + 24'(4 * i)) begin errors++; $display("FAIL wb_addr%0d: got %h want %h", i, mq_addr[i], 24'h100 + 24'(4 * i)); end
                checks++; if (mq_data[i] !== exp_d) begin errors++; $display("FAIL wb_data%0d: got %h want %h", i, mq_data[i], exp_d); end
                checks++; if (mq_be[i] !== 4'hF || mq_we[i] !== 1'b1) begin errors++; $display("FAIL wb_be_we%0d: got be=%h we=%b want be=f we=1", i, mq_be[i], mq_we[i]); end
            end
        end
        checks++; if (wfifo_level !== 4'd0) begin errors++; $display("FAIL wb_level: got %0d want 0", wfifo_level); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int acc;
        clear_mq();
        mem_req_ready = 1'b0;
        hit(32'h0000_0200, 1'b1);
        s_data = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            phase(32'hA0 + i, ok);
            if (ok) acc++;
        end
        checks++; if (acc != 8) begin errors++; $display("FAIL ff_pushes: got %0d want 8", acc); end
        s_data_vld = 1'b1; adio_out = 32'hA8;
        tick(3);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ff_ready_drop: got %b want 0", s_ready); end
        checks++; if (wfifo_level !== 4'd8) begin errors++; $display("FAIL ff_level: got %0d want 8", wfifo_level); end
        checks++; if (mq_we.size() != 0) begin errors++; $display("FAIL ff_no_req: got %0d want 0", mq_we.size()); end
        mem_req_ready = 1'b1;
        phase(32'hA8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ff_resume9: got no accept want accept"); end
        phase(32'hA9, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ff_resume10: got no accept want accept"); end
        s_data = 1'b0;
        wait_mq(10, ok);
        tick(2);
        checks++; if (mq_we.size() != 10) begin errors++; $display("FAIL ff_count: got %0d want 10", mq_we.size()); end
        for (int i = 0; i < 10; i++) begin
            if (mq_we.size() > i) begin
                checks++; if (mq_data[i] !== 32'hA0 + 32'(i) || mq_addr[i] !== 24'h200 + 24'(4 * i)) begin
                    errors++; $display("FAIL ff_order%0d: got %h@%h want %h@%h", i, mq_data[i], mq_addr[i], 32'hA0 + 32'(i), 24'h200 + 24'(4 * i));
                end
            end
        end
    endtask

    task automatic test_raw();
        bit ok;
        clear_mq();
        mem_req_ready = 1'b0;
        hit(32'h0000_0040, 1'b1);
        s_data = 1'b1;
        phase(32'hDEAD_BEEF, ok);
        s_data = 1'b0;
        tick(1);
        hit(32'h0000_0040, 1'b0);
        tick(3);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL raw_drain_ready: got %b want 0", s_ready); end
        checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1) begin errors++; $display("FAIL raw_head_is_write: got v=%b we=%b want v=1 we=1", mem_req_valid, mem_req_we); end
        mem_req_ready = 1'b1;
        wait_mq(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL raw_req_timeout: got %0d reqs want 2", mq_we.size()); end
        if (mq_we.size() >= 2) begin
            checks++; if (mq_we[0] !== 1'b1 || mq_addr[0] !== 24'h40 || mq_data[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_first_write: got we=%b a=%h d=%h want we=1 a=40 d=deadbeef", mq_we[0], mq_addr[0], mq_data[0]); end
            checks++; if (mq_we[1] !== 1'b0 || mq_addr[1] !== 24'h40 || mq_be[1] !== 4'hF) begin errors++; $display("FAIL raw_then_read: got we=%b a=%h be=%h want we=0 a=40 be=f", mq_we[1], mq_addr[1], mq_be[1]); end
        end
        tick(4);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL raw_wait_ready: got %b want 0", s_ready); end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
        tick(1);
        mem_rsp_valid = 1'b0;
        checks++; if (s_ready !== 1'b1 || s_term !== 1'b1) begin errors++; $display("FAIL raw_disc: got rdy=%b term=%b want 1 1", s_ready, s_term); end
        checks++; if (adio_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_data: got %h want deadbeef", adio_in); end
        tick(1);
        checks++; if (s_ready !== 1'b0 || s_term !== 1'b0) begin errors++; $display("FAIL raw_one_cycle: got rdy=%b term=%b want 0 0", s_ready, s_term); end
        checks++; if (s_abort !== 1'b0) begin errors++; $display("FAIL raw_abort: got %b want 0", s_abort); end
    endtask

    task automatic test_latency();
        clear_mq();
        mem_req_ready = 1'b1;
        hit(32'h0000_0082, 1'b0);
        tick(2);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", s_ready); end
        checks++; if (mq_we.size() != 1 || (mq_we.size() == 1 && mq_addr[0] !== 24'h80)) begin errors++; $display("FAIL lat_req: got %0d reqs want 1 at 80", mq_we.size()); end
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        tick(1);
        mem_rsp_valid = 1'b0;
        checks++; if (s_ready !== 1'b1 || s_term !== 1'b1) begin errors++; $display("FAIL lat_ready3: got rdy=%b term=%b want 1 1", s_ready, s_term); end
        checks++; if (adio_in !== 32'h1234_5678) begin errors++; $display("FAIL lat_data: got %h want 12345678", adio_in); end
        tick(1);
    endtask

    task automatic test_wrap();
        clear_mq();
        mem_req_ready = 1'b1;
        hit(32'h00FF_FFFC, 1'b1);
        s_data = 1'b1; s_data_vld = 1'b1; adio_out = 32'h77; s_cbe_n = 4'h0;
        @(negedge clk);
        checks++; if (s_term !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL wrap_term: got term=%b rdy=%b want 1 1", s_term, s_ready); end
        @(posedge clk); #1;
        adio_out = 32'h88;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL wrap_second: got rdy=%b want 0", s_ready); end
        @(posedge clk); #1;
        s_data = 1'b0; s_data_vld = 1'b0;
        tick(3);
        checks++; if (mq_we.size() != 1) begin errors++; $display("FAIL wrap_count: got %0d want 1", mq_we.size()); end
        if (mq_we.size() >= 1) begin
            checks++; if (mq_addr[0] !== 24'hFF_FFFC || mq_data[0] !== 32'h77) begin errors++; $display("FAIL wrap_req: got %h@%h want 77@fffffc", mq_data[0], mq_addr[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mq();
        mem_req_ready = 1'b0;
        hit(32'h0000_0300, 1'b1);
        s_data = 1'b1;
        for (int i = 0; i < 3; i++) phase(32'h300 + i, ok);
        s_data = 1'b0;
        tick(1);
        checks++; if (wfifo_level !== 4'd3) begin errors++; $display("FAIL rm_level_pre: got %0d want 3", wfifo_level); end
        rst = 1'b0;
        tick(1);
        checks++; if (wfifo_level !== 4'd0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_cleared: got lvl=%0d v=%b want 0 0", wfifo_level, mem_req_valid); end
        rst = 1'b1;
        mem_req_ready = 1'b1;
        tick(3);
        checks++; if (mq_we.size() != 0) begin errors++; $display("FAIL rm_no_writes: got %0d want 0", mq_we.size()); end
        hit(32'h0000_0400, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
        tick(1);
        mem_rsp_valid = 1'b0;
        checks++; if (adio_in !== 32'h0 || s_ready !== 1'b0) begin errors++; $display("FAIL rm_stale_rsp: got d=%h rdy=%b want 0 0", adio_in, s_ready); end
        tick(1);
    endtask

`ifdef PCI_MEM_TARGET_RETRY_EN
    task automatic test_retry();
        clear_mq();
        mem_req_ready = 1'b1;
        hit(32'h0000_0500, 1'b0);
        tick(14);
        checks++; if (s_term !== 1'b0) begin errors++; $display("FAIL rt_early: got term=%b want 0", s_term); end
        tick(1);
        checks++; if (s_term !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL rt_retry16: got term=%b rdy=%b want 1 0", s_term, s_ready); end
        tick(1);
        checks++; if (s_term !== 1'b0) begin errors++; $display("FAIL rt_one_cycle: got term=%b want 0", s_term); end
        tick(25);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001;
        tick(1);
        mem_rsp_valid = 1'b0;
        hit(32'h0000_0500, 1'b0);
        checks++; if (s_ready !== 1'b1 || s_term !== 1'b1 || adio_in !== 32'hCAFE_0001) begin errors++; $display("FAIL rt_complete: got rdy=%b term=%b d=%h want 1 1 cafe0001", s_ready, s_term, adio_in); end
        tick(1);
        hit(32'h0000_0600, 1'b0);
        tick(15);
        checks++; if (s_term !== 1'b1) begin errors++; $display("FAIL rt_retry2: got term=%b want 1", s_term); end
        tick(1);
        hit(32'h0000_0700, 1'b0);
        checks++; if (s_abort !== 1'b1) begin errors++; $display("FAIL rt_abort: got %b want 1", s_abort); end
        tick(1);
        checks++; if (s_abort !== 1'b0) begin errors++; $display("FAIL rt_abort_pulse: got %b want 0", s_abort); end
    endtask
`endif

    initial begin
        s_hit = 1'b0; addr = 32'h0; s_wrdn = 1'b0; s_data = 1'b0; s_data_vld = 1'b0;
        adio_out = 32'h0; s_cbe_n = 4'hF; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        test_reset();
        test_write_burst();
        test_fifo_full();
        test_raw();
        test_latency();
        test_wrap();
        test_reset_mid();
`ifdef PCI_MEM_TARGET_RETRY_EN
        test_retry();
`else
        checks++; if (s_abort !== 1'b0) begin errors++; $display("FAIL no_abort: got %b want 0", s_abort); end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pci_mem_target.md
PCI_MEM_TARGET -- requirements
Module: pci_mem_target

Interface
REQ-001 Parameters SHALL be DATA_W=32 (data width, 32 or 64), ADDR_W=24 (memory byte-address width), WFIFO_DEPTH=8 (posted-write entries, power of 2, >=2), RETRY_CYCLES=16 (read-retry timeout).
REQ-002 Ports (name direction width meaning) SHALL be:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- s_hit  in  1  address-phase BAR hit pulse
- addr  in  32  PCI address, valid with s_hit
- s_wrdn  in  1  1=write, 0=read, valid with s_hit
- s_data  in  1  data phases in progress
- s_data_vld  in  1  data phase completes this cycle
- adio_out  in  DATA_W  write data
- s_cbe_n  in  DATA_W/8  active-low byte enables
- adio_in  out  DATA_W  read data
- s_ready / s_term / s_abort  out  1 each  target ready / disconnect / target abort
- mem_req_valid / mem_req_ready  out / in  1 each  memory request handshake
- mem_req_we  out  1  request is write
- mem_req_addr  out  ADDR_W  word-aligned byte address
- mem_req_wdata  out  DATA_W  write data
- mem_req_be  out  DATA_W/8  active-high byte enables
- mem_rsp_valid  in  1  read data return pulse
- mem_rsp_data  in  DATA_W  read data
- wfifo_level  out  log2(WFIFO_DEPTH)+1  FIFO occupancy

Function
REQ-003 On s_hit the block SHALL latch addr[ADDR_W-1:0] with low log2(DATA_W/8) bits cleared, and s_wrdn.
REQ-004 States SHALL be IDLE, WR, RD_DRAIN, RD_REQ, RD_WAIT, RD_DATA, RETRY.
REQ-005 IDLE->WR on s_hit&s_wrdn; IDLE->RD_DRAIN on s_hit&~s_wrdn.
REQ-006 In WR, s_ready SHALL equal FIFO-not-full; each s_data_vld&s_ready SHALL push {addr,adio_out,~s_cbe_n} and advance address by DATA_W/8.
REQ-007 WR->IDLE when s_data deasserts.
REQ-008 If the next write address wraps past 2^ADDR_W-1, s_term SHALL assert with that data phase, and the block SHALL return to IDLE.
REQ-009 FIFO head SHALL drive mem_req_* with mem_req_we=1; pop on mem_req_valid&mem_req_ready; simultaneous push and pop SHALL leave wfifo_level unchanged.
REQ-010 RD_DRAIN SHALL hold s_ready=0 until FIFO empty (read-after-write ordering), then go to RD_REQ.
REQ-011 RD_REQ SHALL assert mem_req_valid with mem_req_we=0, mem_req_be all ones, and latched address; go to RD_WAIT on mem_req_ready.
REQ-012 RD_WAIT: on mem_rsp_valid, register mem_rsp_data into adio_in, go to RD_DATA.
REQ-013 RD_DATA SHALL assert s_ready and s_term together for one cycle (single-word disconnect-with-data), then go to IDLE.
REQ-014 Total read latency, with FIFO empty and mem_req_ready=1, SHALL be s_hit -> s_ready in 3 cycles + memory response latency.
REQ-015 s_abort SHALL be 0 at all times except REQ-018.
REQ-016 s_hit arriving in any state but IDLE SHALL be ignored.

Reset
REQ-017 While rst=0: state IDLE; FIFO empty; wfifo_level=0; s_ready=0; s_term=0; s_abort=0; mem_req_valid=0; adio_in=0. Reset mid-transaction SHALL discard pending writes and any outstanding read response.

Configuration
REQ-018 Macro PCI_MEM_TARGET_RETRY_EN: when defined, a counter SHALL run in RD_DRAIN/RD_REQ/RD_WAIT; at RETRY_CYCLES it SHALL enter RETRY, assert s_term with s_ready=0 for one cycle, keep the read pending, and complete it to adio_in on the retried s_hit to the same address (a different address SHALL assert s_abort one cycle); when undefined, no counter or RETRY state exists and the target waits indefinitely.

Verification
REQ-019 Write burst of 4 at 0x000100, data 0x11..0x44, mem_req_ready=1 -> four requests, addresses 0x100,0x104,0x108,0x10C, be=0xF.
REQ-020 Write burst of 10 with mem_req_ready=0 -> s_ready drops after 8 pushes, wfifo_level=8; releasing ready resumes burst, all 10 delivered in order.
REQ-021 Write 0xDEADBEEF at 0x40 then read 0x40, response 0xDEADBEEF after 5 cycles -> read request issued only after write popped; adio_in=0xDEADBEEF with s_ready=s_term=1.
REQ-022 Write at 0xFFFFFC, 2-phase burst -> s_term on first data phase, one request only.
REQ-023 RETRY_EN, response delayed 40 cycles -> s_term with s_ready=0 at cycle 16; retried hit at same address returns data; different address -> s_abort.
REQ-024 rst pulsed low with 3 entries queued -> wfifo_level=0, mem_req_valid=0 next cycle.
